// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with IDLE/RUN/DONE handshake: one full-adder bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;

    logic               sum_bit_d;
    logic               carry_d;
    logic [WIDTH-1:0]   res_d;
    logic               last_bit;

    // One full-adder slice fed by the operand shift-register LSBs and the carry flop.
    always_comb begin
        sum_bit_d = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
        res_d     = {sum_bit_d, res_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register sees the pre-edge value of every other.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath shift registers are cleared along with the
            // control state so a reset leaves no stale operand bits behind.
            state_q <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Final slice: publish the completed word; carry_q is the carry into the MSB.
                        sum     <= res_d;
                        cout    <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
                        ovf     <= carry_q ^ carry_d;
`endif
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized adds
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    logic         last_ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    // One full transaction; hold keeps start high through RUN and DONE to show it is ignored.
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input bit hold);
        logic [W:0] full;
        int         waited;
        int         ssum;
        waited = 0;
        while (!ready && waited < 40) begin
            tick();
            waited++;
        end
        check("ready_before_start", ready, 1);
        full = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        ssum = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        tick();
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", ready, 0);
        for (int k = 1; k < W; k++) begin
            start = hold;
            scramble_inputs();
            tick();
            check("busy_run", busy, 1);
            check("done_early", done, 0);
            check("sum_hold_run", sum, last_sum);
            check("cout_hold_run", cout, last_cout);
        end
        start = hold;
        scramble_inputs();
        tick();
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("ready_in_done", ready, 0);
        check("sum_result", sum, full[W-1:0]);
        check("cout_result", cout, full[W]);
`ifdef SERIAL_ADD_OVF_EN
        last_ovf = (ssum > (2**(W-1) - 1)) || (ssum < -(2**(W-1)));
        check("ovf_result", ovf, last_ovf);
`endif
        last_sum  = full[W-1:0];
        last_cout = full[W];
        start = hold;
        scramble_inputs();
        tick();
        check("done_one_cycle", done, 0);
        check("ready_after_done", ready, 1);
        check("sum_hold_idle", sum, last_sum);
        check("cout_hold_idle", cout, last_cout);
    endtask

    task automatic reset_mid_run();
        int saw_done;
        saw_done = 0;
        start = 1'b1;
        scramble_inputs();
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_cout", cout, 0);
        rst = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            tick();
            if (done) saw_done++;
        end
        check("rst_mid_no_done", saw_done, 0);
        check("rst_mid_idle", ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        tick();
        tick();
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst = 1'b0;
        tick();

        run_add(8'h5A, 8'h33, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held continuously: accepted only in IDLE, one result every W+2 cycles
        for (int i = 0; i < 3; i++) run_add(8'h10, 8'h20, 1'b0, 1'b1);
        start = 1'b0;
        tick();

        // start in DONE ignored, start in the following IDLE cycle accepted
        run_add(8'hA5, 8'h3C, 1'b1, 1'b1);
        run_add(8'h01, 8'h02, 1'b0, 1'b0);

        reset_mid_run();

        // reset wins over start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("rst_prio_ready", ready, 1);
        check("rst_prio_busy", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_prio_still_idle", ready, 1);

`ifdef SERIAL_ADD_OVF_EN
        run_add(8'h7F, 8'h01, 1'b0, 1'b0);
        run_add(8'h80, 8'h80, 1'b0, 1'b0);
        run_add(8'h5A, 8'h33, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end
        start = 1'b0;
        tick();
        tick();
        check("final_idle", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: ready  output  1  high when the block is in IDLE and will accept start.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: sum  output  WIDTH  registered result.
REQ-012 Port: cout  output  1  registered carry-out.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 ready SHALL equal (state==IDLE), busy SHALL equal (state==RUN), and done SHALL equal (state==DONE).
REQ-015 On an edge where state==IDLE and start==1, the block SHALL load a and b into internal shift registers, load cin into the carry flop, clear the bit counter, and enter RUN.
REQ-016 In RUN, each edge SHALL compute one full-adder bit (LSB first) from the shift register LSBs and the carry flop, shift the sum bit into the result register MSB, update the carry, and increment the counter.
REQ-017 On the WIDTH-th RUN edge, the block SHALL copy the result register to sum and the carry to cout, then enter DONE.
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge, and SHALL be high for exactly one cycle.
REQ-019 DONE SHALL return unconditionally to IDLE on the next edge; start asserted while in DONE SHALL be ignored.
REQ-020 start asserted in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-021 sum and cout SHALL hold their last value from DONE until the next DONE; they SHALL NOT show partial results during RUN.
REQ-022 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-023 The result SHALL equal (a + b + cin) mod 2^WIDTH, and cout SHALL be bit WIDTH of the full sum.

Reset
REQ-024 When rst==1 at an edge, in any state including mid-RUN, the block SHALL enter IDLE and clear sum, cout, the counter, the carry flop and the shift registers to 0.
REQ-025 rst SHALL take priority over start on the same edge.
REQ-026 After rst, ready SHALL be 1 and busy, done, sum and cout SHALL be 0.

Configuration
REQ-027 Macro SERIAL_ADD_OVF_EN: when defined, the block SHALL add an output port ovf (1 bit), registered with sum, equal to the signed two's-complement overflow (carry into MSB XOR carry out of MSB), reset to 0 and held like sum.
REQ-028 When SERIAL_ADD_OVF_EN is undefined, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Basic add, WIDTH=8: a=0x5A, b=0x33, cin=0, start for 1 cycle -> done exactly 8 edges after the accepting edge, sum=0x8D, cout=0, done high 1 cycle, then ready=1.
REQ-030 Carry and wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 Ignored start: start held high continuously with a=0x10, b=0x20 -> accepted only in IDLE, a result of 0x30 every WIDTH+2 cycles, and operand changes mid-RUN have no effect.
REQ-032 Reset mid-operation: rst at the 4th RUN edge -> next cycle state=IDLE, ready=1, busy=0, sum=0x00, cout=0, and no done pulse.
REQ-033 Overflow (SERIAL_ADD_OVF_EN defined): a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x5A, b=0x33 -> ovf=1.
REQ-034 Back-to-back: start re-asserted in the DONE cycle -> ignored; start re-asserted in the following IDLE cycle -> accepted, and the previous sum holds until the new DONE.
